// File: rtl/m_wb_stage_fifo.sv
// rtl/m_wb_stage_fifo.sv - DEPTH-entry in-order buffer between Memory and Writeback with valid/ready handshake and flush
module m_wb_stage_fifo #(
    parameter int WORD_SIZE    = 32,
    parameter int ROB_ID_WIDTH = 7,
    parameter int DEPTH        = 2,
    parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              instruction_type,
    input  logic [WORD_SIZE-1:0]    pc,
    input  logic                    exception,
    input  logic [WORD_SIZE-1:0]    virtual_addr_exception,
    input  logic [WORD_SIZE-1:0]    aluResult,
    input  logic [ROB_ID_WIDTH-1:0] rob_id,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              instruction_type_out,
    output logic [WORD_SIZE-1:0]    pc_out,
    output logic                    exception_out,
    output logic [WORD_SIZE-1:0]    virtual_addr_exception_out,
    output logic [WORD_SIZE-1:0]    aluResult_out,
    output logic [ROB_ID_WIDTH-1:0] rob_id_out,
    output logic [CNT_WIDTH-1:0]    count
);

    // All fields of one M result travel as a single packed word so they can never skew.
    localparam int ENTRY_W = 2 + WORD_SIZE + 1 + WORD_SIZE + WORD_SIZE + ROB_ID_WIDTH;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LP_DEPTH   = CNT_WIDTH'(DEPTH);
    localparam logic [PTR_W-1:0]     LP_PTR_MAX = PTR_W'(DEPTH - 1);

    logic [ENTRY_W-1:0]   r_mem [0:DEPTH-1];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;

    logic                 w_push;
    logic                 w_pop;
    logic [ENTRY_W-1:0]   w_in_entry;
    logic [ENTRY_W-1:0]   w_head;
    logic [PTR_W-1:0]     w_wr_ptr_nxt;
    logic [PTR_W-1:0]     w_rd_ptr_nxt;
    logic [CNT_WIDTH-1:0] w_count_nxt;

    // Handshake flags depend only on the registered count, so out_ready never reaches in_ready.
    assign in_ready  = (r_count < LP_DEPTH);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;

    assign w_in_entry = {instruction_type, pc, exception, virtual_addr_exception, aluResult, rob_id};
    assign w_head     = r_mem[r_rd_ptr];
    assign {instruction_type_out, pc_out, exception_out,
            virtual_addr_exception_out, aluResult_out, rob_id_out} = w_head;

    // Next pointer and occupancy values; flush overrides any concurrent push or pop.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = (r_wr_ptr == LP_PTR_MAX) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                w_rd_ptr_nxt = (r_rd_ptr == LP_PTR_MAX) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + CNT_WIDTH'(1);
            end else if (w_pop && !w_push) begin
                w_count_nxt = r_count - CNT_WIDTH'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Entry storage; reset and flush clear every slot so the idle head reads as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

endmodule

// File: tb/tb_m_wb_stage_fifo.sv
// tb/tb_m_wb_stage_fifo.sv - scoreboard bench for m_wb_stage_fifo (DEPTH=2 and DEPTH=3 instances)
module tb_m_wb_stage_fifo;

    localparam int W  = 32;
    localparam int RW = 7;
    localparam int EW = 2 + W + 1 + W + W + RW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0, in_valid3 = 1'b0;
    logic          out_ready = 1'b0, out_ready3 = 1'b0;
    logic [1:0]    itype = '0;
    logic [W-1:0]  pc = '0, vaddr = '0, alu = '0;
    logic          exc = 1'b0;
    logic [RW-1:0] rob = '0;

    logic          in_ready, out_valid, in_ready3, out_valid3;
    logic [1:0]    itype_o, itype_o3;
    logic [W-1:0]  pc_o, vaddr_o, alu_o, pc_o3, vaddr_o3, alu_o3;
    logic          exc_o, exc_o3;
    logic [RW-1:0] rob_o, rob_o3;
    logic [1:0]    cnt, cnt3;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q2[$];
    logic [EW-1:0] exp_q3[$];

    always #5 clk = ~clk;

    m_wb_stage_fifo #(.WORD_SIZE(W), .ROB_ID_WIDTH(RW), .DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction_type(itype), .pc(pc), .exception(exc),
        .virtual_addr_exception(vaddr), .aluResult(alu), .rob_id(rob),
        .out_valid(out_valid), .out_ready(out_ready),
        .instruction_type_out(itype_o), .pc_out(pc_o), .exception_out(exc_o),
        .virtual_addr_exception_out(vaddr_o), .aluResult_out(alu_o), .rob_id_out(rob_o),
        .count(cnt));

    m_wb_stage_fifo #(.WORD_SIZE(W), .ROB_ID_WIDTH(RW), .DEPTH(3)) dut3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .instruction_type(itype), .pc(pc), .exception(exc),
        .virtual_addr_exception(vaddr), .aluResult(alu), .rob_id(rob),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .instruction_type_out(itype_o3), .pc_out(pc_o3), .exception_out(exc_o3),
        .virtual_addr_exception_out(vaddr_o3), .aluResult_out(alu_o3), .rob_id_out(rob_o3),
        .count(cnt3));

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive the shared payload inputs with a fixed function of the tag; returns the packed entry.
    task automatic set_payload(input int id, output logic [EW-1:0] e);
        rob   = RW'(id);
        itype = 2'(id % 4);
        pc    = 32'h200 + 32'(id * 4);
        exc   = id[0];
        vaddr = 32'hDEAD_0000 + 32'(id);
        alu   = 32'(id * 3) + 32'h1000;
        e     = {itype, pc, exc, vaddr, alu, rob};
    endtask

    // Monitors: whenever a DUT presents a transfer, compare it with the scoreboard head.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            checks++;
            if (exp_q2.size() == 0) begin
                failures++;
                $display("FAIL d2_unexpected_output actual_rob=%0d required=none", rob_o);
            end else begin
                logic [EW-1:0] e;
                e = exp_q2.pop_front();
                if ({itype_o, pc_o, exc_o, vaddr_o, alu_o, rob_o} !== e) begin
                    failures++;
                    $display("FAIL d2_entry actual=0x%0h required=0x%0h",
                             {itype_o, pc_o, exc_o, vaddr_o, alu_o, rob_o}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && out_valid3 && out_ready3) begin
            checks++;
            if (exp_q3.size() == 0) begin
                failures++;
                $display("FAIL d3_unexpected_output actual_rob=%0d required=none", rob_o3);
            end else begin
                logic [EW-1:0] e;
                e = exp_q3.pop_front();
                if ({itype_o3, pc_o3, exc_o3, vaddr_o3, alu_o3, rob_o3} !== e) begin
                    failures++;
                    $display("FAIL d3_entry actual=0x%0h required=0x%0h",
                             {itype_o3, pc_o3, exc_o3, vaddr_o3, alu_o3, rob_o3}, e);
                end
            end
        end
    end

    initial begin
        logic [EW-1:0] e;
        logic [39:0]   rdy_pat;
        int            sent, mcnt, cyc;
        bit            do_push;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_count", W'(cnt), 0);
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_in_ready", W'(in_ready), 1);
        check("rst_alu_out", alu_o, 0);
        tick;
        reset = 1'b1;
        tick;

        // Flow-through
        out_ready = 1'b1;
        set_payload(5, e);
        pc = 32'h100;
        e = {itype, pc, exc, vaddr, alu, rob};
        in_valid = 1'b1;
        exp_q2.push_back(e);
        tick;
        in_valid = 1'b0;
        check("flow_out_valid", W'(out_valid), 1);
        check("flow_pc_out", pc_o, 32'h100);
        check("flow_rob_out", W'(rob_o), 5);
        tick;
        check("flow_drained", W'(out_valid), 0);

        // Back-pressure: third push must be refused
        out_ready = 1'b0;
        set_payload(1, e); in_valid = 1'b1; exp_q2.push_back(e); tick;
        set_payload(2, e); exp_q2.push_back(e); tick;
        check("bp_count_full", W'(cnt), 2);
        check("bp_in_ready", W'(in_ready), 0);
        set_payload(3, e); tick;
        in_valid = 1'b0;
        check("bp_count_hold", W'(cnt), 2);
        check("bp_head_rob", W'(rob_o), 1);
        out_ready = 1'b1;
        tick;
        check("bp_in_ready_after_pop", W'(in_ready), 1);
        tick;
        check("bp_drained", W'(cnt), 0);

        // Simultaneous push and pop at count=1
        out_ready = 1'b0;
        set_payload(7, e); in_valid = 1'b1; exp_q2.push_back(e); tick;
        check("sim_count_pre", W'(cnt), 1);
        set_payload(8, e); exp_q2.push_back(e); out_ready = 1'b1; tick;
        in_valid = 1'b0;
        check("sim_count", W'(cnt), 1);
        check("sim_head_rob", W'(rob_o), 8);
        tick;
        check("sim_drained", W'(cnt), 0);

        // Flush wins over concurrent push and pop
        out_ready = 1'b0;
        set_payload(20, e); in_valid = 1'b1; exp_q2.push_back(e); tick;
        set_payload(21, e); exp_q2.push_back(e); tick;
        check("fl_count_pre", W'(cnt), 2);
        set_payload(22, e); out_ready = 1'b1; flush = 1'b1; tick;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_q2.delete();
        check("fl_count", W'(cnt), 0);
        check("fl_out_valid", W'(out_valid), 0);
        check("fl_pc_out", pc_o, 0);
        check("fl_alu_out", alu_o, 0);
        check("fl_rob_out", W'(rob_o), 0);
        tick;
        check("fl_push_discarded", W'(cnt), 0);

        // Asynchronous reset mid-stream with two held entries
        set_payload(30, e); in_valid = 1'b1; exp_q2.push_back(e); tick;
        set_payload(31, e); exp_q2.push_back(e); tick;
        in_valid = 1'b0;
        check("ar_count_pre", W'(cnt), 2);
        #2 reset = 1'b0;
        #1;
        exp_q2.delete();
        check("ar_count", W'(cnt), 0);
        check("ar_out_valid", W'(out_valid), 0);
        check("ar_in_ready", W'(in_ready), 1);
        check("ar_alu_out", alu_o, 0);
        check("ar_rob_out", W'(rob_o), 0);
        tick;
        reset = 1'b1;
        tick;
        check("ar_count_after", W'(cnt), 0);

        // Wrap on DEPTH=3 with a fixed irregular out_ready pattern
        rdy_pat = 40'b1101_0011_1000_1110_0101_1001_0001_1111_0110_0100;
        sent = 0;
        mcnt = 0;
        cyc  = 0;
        while (!(sent == 10 && mcnt == 0) && cyc < 60) begin
            do_push = (sent < 10) && (mcnt < 3);
            if (do_push) begin
                set_payload(sent, e);
                exp_q3.push_back(e);
            end
            in_valid3  = do_push;
            out_ready3 = (cyc < 40) ? rdy_pat[cyc] : 1'b1;
            tick;
            if (do_push) sent++;
            if (mcnt != 0 && out_ready3) mcnt--;
            if (do_push) mcnt++;
            check("wrap_count", W'(cnt3), W'(mcnt));
            if (cnt3 > 2'd3) begin
                checks++;
                failures++;
                $display("FAIL wrap_count_bound actual=%0d required<=3", cnt3);
            end
            cyc++;
        end
        in_valid3 = 1'b0;
        out_ready3 = 1'b0;
        if (cyc >= 60) begin
            checks++;
            failures++;
            $display("FAIL wrap_timeout actual_cycles=%0d required<60", cyc);
        end
        tick;

        check("q2_left", W'(exp_q2.size()), 0);
        check("q3_left", W'(exp_q3.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
